// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------
// dm_arb_pkg : shared types and constants for the dm_arbiter block
// Revision   : 1.0
// ----------------------------------------------------------------------
`default_nettype none

package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_BURST_DEFAULT = 4;

  localparam logic [31:0] c_word_align_mask = 32'h0000_0003;

  function automatic logic is_word_aligned(input logic [31:0] a);
    return (a & c_word_align_mask) == 32'h0000_0000;
  endfunction

endpackage : dm_arb_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------
// rr_pick : two-way round-robin picker, one-hot grant from valids and rr
// Revision : 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rr_pick (
  input  logic [1:0] i_valid,
  input  logic       i_rr,
  output logic [1:0] o_gnt
);

  // rr names the requester that wins a tie
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt[0] = i_valid[0] && (!i_valid[1] || !i_rr);
    o_gnt[1] = i_valid[1] && (!i_valid[0] ||  i_rr);
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------
// dm_arbiter : two-requester lock/burst arbiter in front of a data memory
// Revision   : 1.0
// ----------------------------------------------------------------------
`default_nettype none

module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic        req0_lock,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req0_pc,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic        req1_lock,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [31:0] req1_pc,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic        MemWrite,
  output logic [31:0] PC,
  output logic [31:0] addr,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] c_bcnt_max = BCNT_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [31:0]       rsp0_rdata_q, rsp0_rdata_d;
  logic [31:0]       rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0]        w_valid;
  logic [1:0]        w_rr_gnt;
  logic [1:0]        w_ready;
  logic [1:0]        w_xfer;
  logic              w_any_xfer;
  logic              w_sel;
  logic              w_sel_we;
  logic              w_sel_lock;
  logic              w_sel_aligned;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [31:0]       w_sel_pc;
  logic              w_bcnt_at_max;
  logic [BCNT_W-1:0] w_bcnt_inc;
  logic              w_own;
  logic              w_own_valid;
  logic              w_other_valid;
  logic              w_rd_ok;

  assign w_valid       = {req1_valid, req0_valid};
  assign w_bcnt_at_max = (bcnt_q == c_bcnt_max);

  rr_pick u_rr_pick (
    .i_valid (w_valid),
    .i_rr    (rr_q),
    .o_gnt   (w_rr_gnt)
  );

  // A saturated owner yields for one cycle when the other side shows up
  always_comb begin
    w_ready = 2'b00;
    unique case (state_q)
      IDLE:    w_ready = w_rr_gnt;
      OWN0:    w_ready = {1'b0, !(w_bcnt_at_max && req1_valid)};
      OWN1:    w_ready = {!(w_bcnt_at_max && req0_valid), 1'b0};
      default: w_ready = 2'b00;
    endcase
    if (!reset) begin
      w_ready = 2'b00;
    end
  end

  assign w_xfer     = w_valid & w_ready;
  assign w_any_xfer = |w_xfer;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  always_comb begin
    w_sel         = w_xfer[1];
    w_sel_we      = w_sel ? req1_we    : req0_we;
    w_sel_lock    = w_sel ? req1_lock  : req0_lock;
    w_sel_addr    = w_sel ? req1_addr  : req0_addr;
    w_sel_wdata   = w_sel ? req1_wdata : req0_wdata;
    w_sel_pc      = w_sel ? req1_pc    : req0_pc;
    w_sel_aligned = is_word_aligned(w_sel_addr);
  end

  assign addr      = w_any_xfer ? w_sel_addr  : 32'h0000_0000;
  assign PC        = w_any_xfer ? w_sel_pc    : 32'h0000_0000;
  assign writeData = w_any_xfer ? w_sel_wdata : 32'h0000_0000;
  assign MemWrite  = w_any_xfer && w_sel_we && w_sel_aligned;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    bcnt_d        = bcnt_q;
    w_own         = (state_q == OWN1);
    w_own_valid   = w_own ? req1_valid : req0_valid;
    w_other_valid = w_own ? req0_valid : req1_valid;
    w_bcnt_inc    = w_bcnt_at_max ? bcnt_q : bcnt_q + BCNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (w_any_xfer) begin
          if (w_sel_lock) begin
            state_d = w_sel ? OWN1 : OWN0;
            bcnt_d  = BCNT_W'(1);
          end else begin
            rr_d = !w_sel;
          end
        end
      end
      OWN0, OWN1: begin
        if (!w_own_valid) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (!w_any_xfer || !w_sel_lock ||
                     (w_other_valid && w_bcnt_inc == c_bcnt_max)) begin
          // Lock released or burst budget spent: hand the next tie to the other side
          state_d = IDLE;
          bcnt_d  = '0;
          rr_d    = !w_own;
        end else begin
          bcnt_d = w_bcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // readData is captured at the transfer edge, so a same-cycle write is not seen
  always_comb begin
    w_rd_ok      = w_any_xfer && !w_sel_we && w_sel_aligned;
    rsp_valid_d  = w_xfer;
    rsp_err_d    = w_xfer & {2{!w_sel_aligned}};
    rsp0_rdata_d = (w_rd_ok && w_xfer[0]) ? readData : 32'h0000_0000;
    rsp1_rdata_d = (w_rd_ok && w_xfer[1]) ? readData : 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      bcnt_q       <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp0_rdata_q <= 32'h0000_0000;
      rsp1_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      bcnt_q       <= bcnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule : dm_arbiter

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ----------------------------------------------------------------------
// tb_dm_arbiter : directed self-checking bench for dm_arbiter with a dm model
// Revision      : 1.0
// ----------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata, req0_pc;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata, req1_pc;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        MemWrite;
  logic [31:0] PC, addr, writeData, readData;

  logic [31:0] mem [0:15];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign readData = mem[addr[5:2]];
  always @(posedge clk) if (MemWrite) mem[addr[5:2]] <= writeData;

  dm_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_pc(req0_pc),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_pc(req1_pc),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .MemWrite(MemWrite), .PC(PC), .addr(addr), .writeData(writeData), .readData(readData)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = 0; req0_wdata = 0; req0_pc = 0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = 0; req1_wdata = 0; req1_pc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_reqs();
    req0_valid = 1; req1_valid = 1; req0_we = 1; req1_we = 1;
    tick(); tick();
    @(negedge clk);
    vectors++; if ({req1_ready, req0_ready, MemWrite} !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b expected 000", {req1_ready, req0_ready, MemWrite}); end
    vectors++; if ({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err} !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp: got %b expected 0000", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}); end
    vectors++; if ((rsp0_rdata | rsp1_rdata) !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0", rsp0_rdata, rsp1_rdata); end
    vectors++; if (dut.state_q !== IDLE || dut.rr_q !== 1'b0 || dut.bcnt_q !== '0) begin miscompares++; $display("FAIL reset_state: got st=%0d rr=%b bcnt=%0d expected 0/0/0", dut.state_q, dut.rr_q, dut.bcnt_q); end
    reset = 1'b1;
    req0_we = 0; req1_we = 0;
    #1;
    vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL release_prio: got %b expected 01", {req1_ready, req0_ready}); end
    clear_reqs();
    tick();
  endtask

  task automatic test_alternate();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h0; req0_wdata = 32'hA0A0_0000; req0_pc = 32'h100;
    req1_valid = 1; req1_we = 1; req1_addr = 32'h4; req1_wdata = 32'hB1B1_0001; req1_pc = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic exp1;
      exp1 = k[0];
      @(negedge clk);
      vectors++; if ({req1_ready, req0_ready} !== (exp1 ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL alt_grant%0d: got %b expected %b", k, {req1_ready, req0_ready}, exp1 ? 2'b10 : 2'b01); end
      vectors++; if (addr !== (exp1 ? 32'h4 : 32'h0) || PC !== (exp1 ? 32'h200 : 32'h100) || MemWrite !== 1'b1) begin miscompares++; $display("FAIL alt_dm%0d: got addr=%h pc=%h we=%b", k, addr, PC, MemWrite); end
      tick();
      vectors++; if ({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err} !== (exp1 ? 4'b1000 : 4'b0100) || (rsp0_rdata | rsp1_rdata) !== 32'h0) begin miscompares++; $display("FAIL alt_rsp%0d: got v=%b%b e=%b%b rd=%h/%h", k, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, rsp0_rdata, rsp1_rdata); end
    end
    clear_reqs();
    vectors++; if (mem[0] !== 32'hA0A0_0000 || mem[1] !== 32'hB1B1_0001) begin miscompares++; $display("FAIL alt_mem: got %h/%h expected a0a00000/b1b10001", mem[0], mem[1]); end
  endtask

  task automatic test_lock_burst();
    req0_valid = 1; req0_lock = 1; req0_addr = 32'h8;
    req1_valid = 1; req1_addr = 32'hC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if ({req1_ready, req0_ready} !== ((k < 4) ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL burst_grant%0d: got %b expected %b", k, {req1_ready, req0_ready}, (k < 4) ? 2'b01 : 2'b10); end
      tick();
      if (k < 4) begin
        vectors++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'h22) begin miscompares++; $display("FAIL burst_rsp0_%0d: got v=%b rd=%h expected 1/00000022", k, rsp0_valid, rsp0_rdata); end
      end else begin
        vectors++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== 32'h33) begin miscompares++; $display("FAIL burst_rsp1: got v=%b rd=%h expected 1/00000033", rsp1_valid, rsp1_rdata); end
      end
    end
    clear_reqs();
    vectors++; if (dut.rr_q !== 1'b0 || dut.state_q !== IDLE) begin miscompares++; $display("FAIL burst_rr: got rr=%b st=%0d expected 0/IDLE", dut.rr_q, dut.state_q); end
  endtask

  task automatic test_read_after_write();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h4; req0_wdata = 32'h3;
    @(negedge clk);
    vectors++; if (req0_ready !== 1'b1 || MemWrite !== 1'b1) begin miscompares++; $display("FAIL raw_write: got rdy=%b we=%b expected 1/1", req0_ready, MemWrite); end
    tick();
    clear_reqs();
    req1_valid = 1; req1_addr = 32'h4;
    @(negedge clk);
    vectors++; if (req1_ready !== 1'b1 || MemWrite !== 1'b0) begin miscompares++; $display("FAIL raw_read: got rdy=%b we=%b expected 1/0", req1_ready, MemWrite); end
    tick();
    vectors++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h3 || rsp1_err !== 1'b0) begin miscompares++; $display("FAIL raw_rsp: got v=%b rd=%h err=%b expected 1/00000003/0", rsp1_valid, rsp1_rdata, rsp1_err); end
    clear_reqs();
  endtask

  task automatic test_misaligned();
    req1_valid = 1; req1_we = 1; req1_addr = 32'h6; req1_wdata = 32'h10;
    @(negedge clk);
    vectors++; if (req1_ready !== 1'b1 || MemWrite !== 1'b0) begin miscompares++; $display("FAIL mis_wr_dm: got rdy=%b we=%b expected 1/0", req1_ready, MemWrite); end
    tick();
    vectors++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_rdata !== 32'h0) begin miscompares++; $display("FAIL mis_wr_rsp: got v=%b err=%b rd=%h expected 1/1/0", rsp1_valid, rsp1_err, rsp1_rdata); end
    vectors++; if (mem[1] !== 32'h3) begin miscompares++; $display("FAIL mis_wr_mem: got %h expected 00000003", mem[1]); end
    clear_reqs();
    req0_valid = 1; req0_addr = 32'h9;
    tick();
    vectors++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'h0) begin miscompares++; $display("FAIL mis_rd_rsp: got v=%b err=%b rd=%h expected 1/1/0", rsp0_valid, rsp0_err, rsp0_rdata); end
    clear_reqs();
  endtask

  task automatic test_reset_midburst();
    req1_valid = 1; req1_lock = 1; req1_addr = 32'h8;
    tick();
    vectors++; if (dut.state_q !== OWN1) begin miscompares++; $display("FAIL mid_own1: got st=%0d expected OWN1", dut.state_q); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({req1_ready, req0_ready, MemWrite} !== 3'b000) begin miscompares++; $display("FAIL mid_ready: got %b expected 000", {req1_ready, req0_ready, MemWrite}); end
    tick();
    vectors++; if (dut.state_q !== IDLE || dut.bcnt_q !== '0 || rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got st=%0d bcnt=%0d rspv=%b expected IDLE/0/0", dut.state_q, dut.bcnt_q, rsp1_valid); end
    clear_reqs();
    reset = 1'b1;
    tick();
    vectors++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL mid_release: got rspv=%b%b expected 00", rsp1_valid, rsp0_valid); end
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL mid_prio: got %b expected 01", {req1_ready, req0_ready}); end
    clear_reqs();
    tick();
  endtask

  task automatic test_stream();
    req0_valid = 1; req0_lock = 1; req0_addr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL stream_grant%0d: got %b expected 01", k, {req1_ready, req0_ready}); end
      tick();
      vectors++; if (rsp0_valid !== 1'b1 || dut.state_q !== OWN0) begin miscompares++; $display("FAIL stream_rsp%0d: got v=%b st=%0d expected 1/OWN0", k, rsp0_valid, dut.state_q); end
    end
    vectors++; if (dut.bcnt_q !== 3'd4) begin miscompares++; $display("FAIL stream_bcnt: got %0d expected 4", dut.bcnt_q); end
    req0_valid = 0;
    tick();
    vectors++; if (dut.state_q !== IDLE || rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drop: got st=%0d v=%b expected IDLE/0", dut.state_q, rsp0_valid); end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[2] = 32'h0000_0022;
    mem[3] = 32'h0000_0033;
    test_reset();
    test_alternate();
    test_lock_burst();
    test_read_after_write();
    test_misaligned();
    test_reset_midburst();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dm_arbiter

`default_nettype wire
